// File: rtl/mem_port_pkg.sv
// Shared constants and types for the memory port controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_port_pkg;

  // Default data word: instruction 6 + register address 4 + memory address 6.
  localparam int WORD_SIZE     = 16;
  localparam int MEM_ADDR_SIZE = 6;

  // Wait-state counter width; covers WAIT_CYCLES 0..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter: loads a start value, decrements while enabled, flags zero.
// Latency: load/decrement take effect on the next rising edge; zero is combinational from the count.
// Backpressure: none; it stops at zero rather than wrapping.
// Ports: clock, reset (async active-low), load + load_val, dec, zero.
module mem_wait_counter
  import mem_port_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory port controller: captures one CPU request, runs a strobed memory access, answers with a four-phase ack.
// Latency: cpu_ack rises WAIT_CYCLES+2 edges after the capture edge (posted writes: 1 edge after capture).
// Backpressure: one access in flight; cpu_req is only sampled in IDLE, busy is high otherwise.
// Ports: clock, reset (async active-low); cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_ack/cpu_rdata/busy out;
//        mem_read/mem_write strobes, mem_address_bus, data_to_mem out; data_from_mem in.
// Config: define MEM_PORT_CTRL_POST_WRITE_EN to acknowledge writes early while the memory write completes.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int WORD_SIZE     = mem_port_pkg::WORD_SIZE,
  parameter int MEM_ADDR_SIZE = mem_port_pkg::MEM_ADDR_SIZE,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [MEM_ADDR_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0]     cpu_wdata,
  output logic                     cpu_ack,
  output logic [WORD_SIZE-1:0]     cpu_rdata,
  output logic                     busy,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [MEM_ADDR_SIZE-1:0] mem_address_bus,
  output logic [WORD_SIZE-1:0]     data_to_mem,
  input  logic [WORD_SIZE-1:0]     data_from_mem
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  state_t                   state;
  state_t                   state_nxt;
  logic                     we_q;
  logic [MEM_ADDR_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0]     wdata_q;
  logic                     ack_nxt;
  logic                     hs_q;       // CPU handshake already completed for the current access
  logic                     posted;     // current access acknowledges before the memory finishes
  logic                     capture;
  logic                     in_access;
  logic                     cnt_zero;
  logic                     last_access;
  logic                     ack_fall;

  assign capture     = (state == IDLE) && cpu_req;
  assign in_access   = (state == ACCESS);
  assign last_access = in_access && cnt_zero;
  assign ack_fall    = cpu_ack && !cpu_req;

`ifdef MEM_PORT_CTRL_POST_WRITE_EN
  assign posted = we_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hs_q <= 1'b0;
    end else if (capture) begin
      hs_q <= 1'b0;
    end else if (ack_fall) begin
      hs_q <= 1'b1;
    end
  end
`else
  assign posted = 1'b0;
  assign hs_q   = 1'b0;
`endif

  // Counter is loaded on the capture edge, so ACCESS spans WAIT_CYCLES+1 cycles.
  mem_wait_counter u_wait_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (capture),
    .load_val (WAIT_LOAD),
    .dec      (in_access),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = cpu_ack;
    case (state)
      IDLE: begin
        if (cpu_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (cnt_zero) state_nxt = DONE;
        // Only a posted write can be acknowledged (and released) while the strobe is still running.
        if (ack_fall) begin
          ack_nxt = 1'b0;
        end else if (posted && !cpu_ack && !hs_q) begin
          ack_nxt = 1'b1;
        end
      end
      DONE: begin
        if (ack_fall) begin
          ack_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (!cpu_ack && hs_q) begin
          state_nxt = IDLE;
        end else if (!cpu_ack) begin
          ack_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_ack   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= ack_nxt;
      if (capture) begin
        we_q    <= cpu_we;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end
      if (last_access && !we_q) begin
        cpu_rdata <= data_from_mem;
      end
    end
  end

  // Strobes decode straight from the state register so reset drops them without a clock edge.
  assign busy            = (state != IDLE);
  assign mem_read        = in_access && !we_q;
  assign mem_write       = in_access && we_q;
  assign mem_address_bus = addr_q;
  assign data_to_mem     = wdata_q;

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 Parameter WORD_SIZE, default 16, data word width (instruction 6 + register address 4 + memory address 6).
REQ-002 Parameter MEM_ADDR_SIZE, default 6, memory address width.
REQ-003 Parameter WAIT_CYCLES, default 2, extra cycles each memory strobe is held; range 0..15.
REQ-004 Port clock, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port cpu_req, input, 1, CPU access request; held high until cpu_ack seen.
REQ-007 Port cpu_we, input, 1, 1 = write, 0 = read; sampled with cpu_req.
REQ-008 Port cpu_addr, input, MEM_ADDR_SIZE, access address.
REQ-009 Port cpu_wdata, input, WORD_SIZE, write data.
REQ-010 Port cpu_ack, output, 1, access complete (four-phase handshake).
REQ-011 Port cpu_rdata, output, WORD_SIZE, read result; valid while cpu_ack high after a read.
REQ-012 Port busy, output, 1, high whenever state is not IDLE.
REQ-013 Port mem_read, output, 1, memory read strobe.
REQ-014 Port mem_write, output, 1, memory write strobe.
REQ-015 Port mem_address_bus, output, MEM_ADDR_SIZE, memory address.
REQ-016 Port data_to_mem, output, WORD_SIZE, memory write data.
REQ-017 Port data_from_mem, input, WORD_SIZE, memory read data.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-019 IDLE: cpu_req high at a rising edge SHALL capture cpu_we, cpu_addr, cpu_wdata and move to ACCESS; CPU-side changes after capture are ignored.
REQ-020 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, counted by a 4-bit down-counter loaded with WAIT_CYCLES on entry; WAIT_CYCLES=0 gives one cycle.
REQ-021 In ACCESS exactly one of mem_read/mem_write SHALL be high per captured cpu_we; mem_address_bus and data_to_mem SHALL hold captured values.
REQ-022 mem_read and mem_write SHALL never be high simultaneously and SHALL both be low outside ACCESS.
REQ-023 On the last ACCESS cycle a read SHALL register data_from_mem into cpu_rdata.
REQ-024 DONE SHALL hold cpu_ack high until cpu_req is sampled low, then return to IDLE with cpu_ack low.
REQ-025 Latency: cpu_ack SHALL rise WAIT_CYCLES+2 rising edges after the edge that captured the request.
REQ-026 A new request SHALL NOT be sampled in the cycle cpu_ack falls; earliest capture is the next IDLE edge.
REQ-027 cpu_rdata SHALL hold its last value across writes and idle periods.

Reset
REQ-028 reset low SHALL immediately force IDLE, counter 0, cpu_ack 0, busy 0, mem_read 0, mem_write 0, mem_address_bus 0, data_to_mem 0, cpu_rdata 0.
REQ-029 Reset during ACCESS SHALL abort the access with strobes dropped asynchronously; no ack issued for it.
REQ-030 Operation SHALL resume at the first rising edge after reset deasserts.

Configuration
REQ-031 Macro MEM_PORT_CTRL_POST_WRITE_EN: when defined, a captured write SHALL raise cpu_ack on the cycle after capture while the memory write completes in ACCESS; DONE is entered only after both ACCESS ends and cpu_req is low.
REQ-032 With the macro defined, busy SHALL remain high until the posted write finishes, and no new request is captured before that.
REQ-033 Without the macro, writes SHALL follow REQ-024/025 exactly like reads.

Structure
REQ-034 Package mem_port_pkg SHALL hold WORD_SIZE, MEM_ADDR_SIZE, the state encoding constants (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), and counter width.
REQ-035 The wait-state down-counter SHALL be the sub-module mem_wait_counter (load, decrement, zero flag).

Verification
REQ-036 WAIT_CYCLES=2, read addr 6'h05, memory holds 16'hA5C3 -> mem_read high 3 cycles, cpu_ack 4 edges after capture, cpu_rdata=16'hA5C3.
REQ-037 Write 16'h1234 to 6'h3F then read 6'h3F -> mem_write high 3 cycles with address 6'h3F, read returns 16'h1234.
REQ-038 WAIT_CYCLES=0, back-to-back reads 6'h00, 6'h01 -> each ACCESS 1 cycle, cpu_ack 2 edges after each capture, strobes never overlap.
REQ-039 reset low mid-ACCESS of a write -> mem_write drops with no clock edge, cpu_ack never asserts, busy=0.
REQ-040 cpu_addr changed to 6'h10 during ACCESS of read 6'h02 -> mem_address_bus stays 6'h02.
REQ-041 Macro defined, write 6'h08 then immediate read request -> cpu_ack one cycle after write capture, read captured only after mem_write deasserts.
